// File: rtl/demux_pkg.sv
// demux_pkg: shared constants, slot state type and channel slice helper for demux_1ton_reg
package demux_pkg;
  localparam int MAX_CH = 16;
  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;
  function automatic int ch_off(input int ch, input int w);
    return ch * w;
  endfunction
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry output buffer with EMPTY/FULL state; zero-fills data while empty
module demux_slot import demux_pkg::*; #(
  parameter int DATA_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [DATA_LENGTH-1:0] wdata,
  input  logic                   ready,
  output logic                   valid,
  output logic [DATA_LENGTH-1:0] data
);
  slot_state_e state, state_nx;
  logic [DATA_LENGTH-1:0] word;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SLOT_EMPTY;
      word  <= '0;
    end else begin
      state <= state_nx;
      if (load) word <= wdata;
    end
  end
  // A load while full is only ever granted together with a drain, so it simply replaces the word
  always_comb begin
    state_nx = state;
    state_nx = load ? SLOT_FULL : ((state == SLOT_FULL && ready) ? SLOT_EMPTY : state);
  end
  assign valid = state == SLOT_FULL;
  assign data  = valid ? word : '0;
endmodule

// File: rtl/demux_1ton_reg.sv
// demux_1ton_reg: registered 1-to-N valid/ready demux; per-channel drain counters with DEMUX_CNT_EN
module demux_1ton_reg import demux_pkg::*; #(
  parameter int DATA_LENGTH = 32,
  parameter int NUM_CH      = 4,
  parameter int SEL_W       = $clog2(NUM_CH)
`ifdef DEMUX_CNT_EN
  , parameter int CNT_W     = 16
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SEL_W-1:0]              in_sel,
  input  logic [DATA_LENGTH-1:0]        in_data,
  output logic [NUM_CH-1:0]             out_valid,
  input  logic [NUM_CH-1:0]             out_ready,
  output logic [NUM_CH*DATA_LENGTH-1:0] out_data,
  output logic                          sel_err
`ifdef DEMUX_CNT_EN
  , output logic [NUM_CH*CNT_W-1:0]     ch_count
`endif
);
  localparam int PADN = 1 << SEL_W;
  localparam logic [SEL_W:0] NCH = (SEL_W+1)'(NUM_CH);
  if (NUM_CH < 2 || NUM_CH > MAX_CH) begin : g_bad_cfg
    $error("NUM_CH out of range");
  end
  logic [PADN-1:0] full_pad, rdy_pad;
  logic [NUM_CH-1:0] load;
  logic bad_sel;
  // Pad to the full selector range so out-of-range indices read as empty
  assign full_pad = PADN'(out_valid);
  assign rdy_pad  = PADN'(out_ready);
  assign bad_sel  = {1'b0, in_sel} >= NCH;
  assign in_ready = bad_sel || !full_pad[in_sel] || rdy_pad[in_sel];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sel_err <= 1'b0;
    else sel_err <= in_valid && bad_sel;
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign load[i] = in_valid && in_ready && in_sel == SEL_W'(i);
    demux_slot #(.DATA_LENGTH(DATA_LENGTH)) u_slot (
      .clk   (clk),
      .reset (reset),
      .load  (load[i]),
      .wdata (in_data),
      .ready (out_ready[i]),
      .valid (out_valid[i]),
      .data  (out_data[ch_off(i, DATA_LENGTH) +: DATA_LENGTH])
    );
`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt <= '0;
      else if (out_valid[i] && out_ready[i]) cnt <= cnt + 1'b1;
    end
    assign ch_count[ch_off(i, CNT_W) +: CNT_W] = cnt;
`endif
  end
endmodule

// File: tb/tb_demux_1ton_reg.sv
// tb_demux_1ton_reg: directed checks of a 4-channel and a 3-channel demux (counters with DEMUX_CNT_EN)
module tb_demux_1ton_reg;
  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [1:0] in_sel = '0;
  logic [31:0] in_data = '0;
  logic [3:0] out_valid, out_ready = 4'hF;
  logic [127:0] out_data;
  logic sel_err;
  logic in_valid3 = 1'b0, in_ready3, sel_err3;
  logic [1:0] in_sel3 = '0;
  logic [31:0] in_data3 = '0;
  logic [2:0] out_valid3, out_ready3 = 3'h7;
  logic [95:0] out_data3;
  int n_chk = 0, n_fail = 0;
`ifdef DEMUX_CNT_EN
  logic [63:0] ch_count;
  logic [47:0] ch_count3;
`endif
  always #5 clk = ~clk;
  demux_1ton_reg #(.DATA_LENGTH(32), .NUM_CH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sel_err(sel_err)
`ifdef DEMUX_CNT_EN
    , .ch_count(ch_count)
`endif
  );
  demux_1ton_reg #(.DATA_LENGTH(32), .NUM_CH(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3), .in_sel(in_sel3),
    .in_data(in_data3), .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .sel_err(sel_err3)
`ifdef DEMUX_CNT_EN
    , .ch_count(ch_count3)
`endif
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick(); tick();
    chk("rst_valid", 128'(out_valid), 128'h0);
    chk("rst_data", out_data, 128'h0);
    chk("rst_err", 128'(sel_err), 128'h0);
    reset = 1'b0;
    // single word to channel 2
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hDEADBEEF;
    #1 chk("ch2_ready", 128'(in_ready), 128'h1);
    tick();
    in_valid = 1'b0;
    chk("ch2_valid", 128'(out_valid), 128'h4);
    chk("ch2_data", out_data, {32'h0, 32'hDEADBEEF, 64'h0});
    tick();
    chk("ch2_drained", 128'(out_valid), 128'h0);
    // channel 1 stalled: second word must wait
    out_ready = 4'b1101;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'hA1;
    #1 chk("ch1_first_ready", 128'(in_ready), 128'h1);
    tick();
    in_data = 32'hA2;
    #1 chk("ch1_second_blocked", 128'(in_ready), 128'h0);
    chk("ch1_hold_valid", 128'(out_valid), 128'h2);
    tick();
    chk("ch1_stable_valid", 128'(out_valid), 128'h2);
    chk("ch1_stable_data", 128'(out_data[63:32]), 128'hA1);
    // channel 3 bypasses the stalled channel 1
    in_sel = 2'd3; in_data = 32'hC3;
    #1 chk("ch3_ready", 128'(in_ready), 128'h1);
    tick();
    chk("ch3_valid", 128'(out_valid), 128'hA);
    chk("ch3_data", out_data, {32'hC3, 32'h0, 32'hA1, 32'h0});
    // drain A1 while loading A2 into channel 1
    in_sel = 2'd1; in_data = 32'hA2; out_ready = 4'hF;
    #1 chk("ch1_replace_ready", 128'(in_ready), 128'h1);
    tick();
    in_valid = 1'b0;
    chk("ch1_replace_valid", 128'(out_valid), 128'h2);
    chk("ch1_replace_data", out_data, {32'h0, 32'h0, 32'hA2, 32'h0});
    tick();
    chk("ch1_empty", 128'(out_valid), 128'h0);
    // streaming into channel 0 without bubbles
    in_valid = 1'b1; in_sel = 2'd0;
    for (int k = 0; k < 8; k++) begin
      in_data = 32'h100 + 32'(k);
      tick();
      chk("stream_valid", 128'(out_valid), 128'h1);
      chk("stream_data", out_data, {96'h0, 32'h100 + 32'(k)});
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end", 128'(out_valid), 128'h0);
    // out-of-range selector on the 3-channel instance
    in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 32'hFFFF;
    #1 chk("bad_sel_ready", 128'(in_ready3), 128'h1);
    tick();
    in_valid3 = 1'b0;
    chk("bad_sel_err", 128'(sel_err3), 128'h1);
    chk("bad_sel_valid", 128'(out_valid3), 128'h0);
    tick();
    chk("bad_sel_err_pulse", 128'(sel_err3), 128'h0);
    chk("bad_sel_valid2", 128'(out_valid3), 128'h0);
    in_valid3 = 1'b1; in_sel3 = 2'd2; in_data3 = 32'h33;
    tick();
    in_valid3 = 1'b0;
    chk("good_sel_valid", 128'(out_valid3), 128'h4);
    chk("good_sel_err", 128'(sel_err3), 128'h0);
    chk("good_sel_data", out_data3, {32'h33, 64'h0});
    // reset while channels 0 and 2 are full
    out_ready = 4'b1010;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h11;
    tick();
    in_sel = 2'd2; in_data = 32'h22;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", 128'(out_valid), 128'h5);
    reset = 1'b1;
    #1 chk("async_rst_valid", 128'(out_valid), 128'h0);
    chk("async_rst_data", out_data, 128'h0);
    tick();
    reset = 1'b0;
    out_ready = 4'hF;
    tick();
    chk("no_replay", 128'(out_valid), 128'h0);
`ifdef DEMUX_CNT_EN
    chk("cnt_cleared", 128'(ch_count), 128'h0);
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'h5;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("cnt_once", 128'(ch_count), 128'h0000_0001_0000_0000);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/demux_1ton_reg.md
Name: demux_1toN_reg

Overview:
- Parametrised, registered 1-to-N demultiplexer with valid/ready handshake on input and on every output channel.
- Generalises the two-way combinational demux to N channels, each with its own one-entry output buffer, so the producer and the consumers are decoupled by one pipeline stage.
- Used in the pipeline to route a single result stream, such as writeback data, to one of several consumers.

Parameters:
- DATA_LENGTH, 32: width in bits of each data word.
- NUM_CH, 4: number of output channels; legal range 2..16.
- SEL_W, $clog2(NUM_CH): width of the channel selector; derived, do not override.
- CNT_W, 16: width of the per-channel transfer counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts the input word this cycle.
- in_sel  in  SEL_W  destination channel index.
- in_data  in  DATA_LENGTH  input word.
- out_valid  out  NUM_CH  per-channel valid, bit i = channel i.
- out_ready  in  NUM_CH  per-channel consumer ready.
- out_data  out  NUM_CH*DATA_LENGTH  flattened; channel i occupies bits [i*DATA_LENGTH +: DATA_LENGTH].
- sel_err  out  1  one-cycle pulse when an out-of-range selector is accepted.
- ch_count  out  NUM_CH*CNT_W  per-channel transfer counts; present only with DEMUX_CNT_EN.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - all slots EMPTY; out_valid=0, out_data=0, sel_err=0, ch_count=0.
- Per-channel slot FSM, two states:
  - EMPTY -> FULL on a load.
  - FULL -> EMPTY on a drain with no simultaneous load.
  - FULL -> FULL on a drain with a simultaneous load; the new word replaces the old one.
- Definitions:
  - load(i): in_valid && in_ready && in_sel==i.
  - drain(i): out_valid[i] && out_ready[i].
- Ready rule: in_ready = (in_sel>=NUM_CH) || !full[in_sel] || out_ready[in_sel].
  - Combinational from out_ready; no combinational path from in_valid to in_ready.
- Latency: a word accepted in cycle t appears on its channel with out_valid set in cycle t+1.
- Sustained throughput: one word per cycle per active channel when that consumer holds ready high.
- Data rules:
  - out_data for channel i holds its stored word while FULL and is driven to 0 while EMPTY (zero-fill for non-selected channels).
  - Data and valid are stable while out_valid[i]=1 and out_ready[i]=0.
- Out-of-range selector (in_sel>=NUM_CH, possible only when NUM_CH is not a power of 2):
  - the word is accepted and dropped;
  - sel_err=1 in cycle t+1;
  - no slot changes.
- Channel independence: a back-pressured channel never blocks a word destined for a different channel.
- in_valid=0: no slot loads; in_sel and in_data are ignored.
- Reset mid-operation: all buffered words are discarded immediately; nothing replays after release.

Optional Feature:
- Macro: DEMUX_CNT_EN.
- Defined:
  - each channel keeps a CNT_W-bit counter that increments on drain(i);
  - the counter wraps from 2^CNT_W-1 to 0;
  - counters are exported on ch_count and cleared by reset.
- Undefined: no counters, no ch_count port, and no area cost.

Decomposition:
- Package demux_pkg:
  - MAX_CH=16 constant;
  - slot-state typedef enum {SLOT_EMPTY, SLOT_FULL};
  - function for the channel slice offset.
- Sub-module demux_slot: one-entry buffer plus FSM, parametrised by DATA_LENGTH.
  - Instantiated NUM_CH times in a generate loop.
  - Top level holds only the select decode, the ready mux, error generation and the optional counters.

Test Plan:
- After reset, with all out_ready=1, drive in_sel=2, in_data=32'hDEADBEEF for one cycle.
  - Next cycle: out_valid=4'b0100, channel 2 data=DEADBEEF, all other channels 0.
- Hold out_ready[1]=0 and send two words to channel 1.
  - First word accepted; in_ready=0 on the second until out_ready[1] rises; the first word is held stable throughout.
- With channel 1 FULL and stalled, send to channel 3.
  - Accepted immediately; channel 3 valid the next cycle; channel 1 unchanged.
- Keep in_valid=1 and out_ready[0]=1 for 8 cycles, incrementing data each cycle.
  - Channel 0 emits 8 consecutive words, one per cycle, with no bubbles.
- Set NUM_CH=3 and drive in_sel=3.
  - in_ready=1; sel_err pulses for 1 cycle; out_valid stays 0.
- Assert reset while slots 0 and 2 are FULL.
  - out_valid=0 in the same cycle.
  - With DEMUX_CNT_EN defined, ch_count=0 and, after release, increments exactly once per drained word.
